// File: rtl/msu_in_deser.sv
// Input deserializer for the MSU squaring core: packs AXI beats LSB-first into {value, end, start}.
// Define MSU_DESER_LEN_CHECK_EN to check frame length against s_axis_tlast and flag errors on o_err.
module msu_in_deser #(
  parameter int unsigned AXI_LEN  = 32,
  parameter int unsigned T_LEN    = 64,
  parameter int unsigned DAT_BITS = 1024  // mirrors redun_mont_pkg::DAT_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [AXI_LEN-1:0]   s_axis_tdata,
  input  logic [AXI_LEN/8-1:0] s_axis_tkeep,
  input  logic                 s_axis_tlast,
  input  logic                 ap_start,
  output logic                 o_val,
  input  logic                 i_rdy,
  output logic [T_LEN-1:0]     o_start_cnt,
  output logic [T_LEN-1:0]     o_end_cnt,
  output logic [DAT_BITS-1:0]  o_value,
  output logic                 o_err
);

  localparam int unsigned Tot      = 2 * T_LEN + DAT_BITS;
  localparam int unsigned NumWords = (Tot + AXI_LEN - 1) / AXI_LEN;
  localparam int unsigned BufW     = NumWords * AXI_LEN;
  localparam int unsigned CntW     = $clog2(NumWords + 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(NumWords - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StHold} state_e;

  state_e                           state_q, state_d;
  logic [CntW-1:0]                  beat_q, beat_d;
  logic [NumWords-1:0][AXI_LEN-1:0] words_q;
  logic [BufW-1:0]                  frame;
  logic                             beat_acc;
  logic                             last_beat;
  logic                             store;
  logic                             unused_in;

  assign beat_acc  = s_axis_tvalid & s_axis_tready;
  assign last_beat = (beat_q == LastBeat);

`ifdef MSU_DESER_LEN_CHECK_EN
  logic drain_q, drain_d;
  logic err_q, err_d;

  // Beats swallowed while hunting for tlast after an overlong frame never reach the outputs.
  assign store     = beat_acc & ~drain_q;
  assign o_err     = err_q;
  assign unused_in = ^s_axis_tkeep;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end
`else
  assign store     = beat_acc;
  assign o_err     = 1'b0;
  assign unused_in = ^{s_axis_tkeep, s_axis_tlast};
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
`ifdef MSU_DESER_LEN_CHECK_EN
    drain_d = drain_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          state_d = StRecv;
          beat_d  = '0;
        end
      end
      StRecv: begin
        if (beat_acc) begin
`ifdef MSU_DESER_LEN_CHECK_EN
          if (drain_q) begin
            if (s_axis_tlast) begin
              state_d = StIdle;
              drain_d = 1'b0;
            end
          end else if (last_beat) begin
            if (s_axis_tlast) begin
              state_d = StHold;
            end else begin
              err_d   = 1'b1;
              drain_d = 1'b1;
            end
          end else if (s_axis_tlast) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
`else
          if (last_beat) begin
            state_d = StHold;
          end else begin
            beat_d = beat_q + 1'b1;
          end
`endif
        end
      end
      StHold: begin
        if (i_rdy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    s_axis_tready = 1'b0;
    o_val         = 1'b0;
    unique case (state_q)
      StRecv:  s_axis_tready = 1'b1;
      StHold:  o_val         = 1'b1;
      default: ;
    endcase
  end

  // Frame buffer; the o_* fields are direct slices so they only move on stored beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_q <= '0;
    end else if (store) begin
      words_q[beat_q] <= s_axis_tdata;
    end
  end

  assign frame       = words_q;
  assign o_start_cnt = frame[T_LEN-1:0];
  assign o_end_cnt   = frame[2*T_LEN-1:T_LEN];
  assign o_value     = frame[Tot-1:2*T_LEN];

  if (BufW > Tot) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^frame[BufW-1:Tot];
  end

endmodule

// File: tb/tb_msu_in_deser.sv
// Self-checking bench for msu_in_deser: table of random frames against a frame-packing model,
// plus hand-written reset, pre-start and (when MSU_DESER_LEN_CHECK_EN is set) length-error cases.
module tb_msu_in_deser;

  localparam int AXI_LEN   = 32;
  localparam int T_LEN     = 64;
  localparam int DAT_BITS  = 1024;
  localparam int TOT       = 2 * T_LEN + DAT_BITS;
  localparam int NUM_WORDS = (TOT + AXI_LEN - 1) / AXI_LEN;
  localparam int BUF_W     = NUM_WORDS * AXI_LEN;
`ifdef MSU_DESER_LEN_CHECK_EN
  localparam int ODD_TLAST = NUM_WORDS - 1;
`else
  localparam int ODD_TLAST = 20;  // tlast is ignored in this build
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 s_axis_tvalid = 1'b0;
  logic                 s_axis_tready;
  logic [AXI_LEN-1:0]   s_axis_tdata = '0;
  logic [AXI_LEN/8-1:0] s_axis_tkeep = '0;
  logic                 s_axis_tlast = 1'b0;
  logic                 ap_start = 1'b0;
  logic                 o_val;
  logic                 i_rdy = 1'b0;
  logic [T_LEN-1:0]     o_start_cnt;
  logic [T_LEN-1:0]     o_end_cnt;
  logic [DAT_BITS-1:0]  o_value;
  logic                 o_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  msu_in_deser #(
    .AXI_LEN (AXI_LEN),
    .T_LEN   (T_LEN),
    .DAT_BITS(DAT_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .ap_start     (ap_start),
    .o_val        (o_val),
    .i_rdy        (i_rdy),
    .o_start_cnt  (o_start_cnt),
    .o_end_cnt    (o_end_cnt),
    .o_value      (o_value),
    .o_err        (o_err)
  );

  typedef struct {
    logic [T_LEN-1:0]    start_cnt;
    logic [T_LEN-1:0]    end_cnt;
    logic [DAT_BITS-1:0] value;
    int                  mode;       // 0: tvalid held, 1: toggled, 2: random
    int                  tlast_at;
    int                  rdy_delay;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs[NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DAT_BITS-1:0] act,
                     input logic [DAT_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [DAT_BITS-1:0] rand_value();
    logic [DAT_BITS-1:0] r;
    for (int i = 0; i < DAT_BITS / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: the frame is {value, end, start} read LSB-first; beat k is bits [k*AXI_LEN +: AXI_LEN].
  function automatic logic [BUF_W-1:0] build_frame(input vec_t v);
    logic [BUF_W-1:0] f;
    f = '0;
    f[TOT-1:0] = {v.value, v.end_cnt, v.start_cnt};
    return f;
  endfunction

  // Offers nbeats beats; ap_start is also poked mid-frame, which must be ignored.
  task automatic send_beats(input logic [BUF_W-1:0] fb, input int nbeats, input int tlast_at,
                            input int mode, output bit ok, output int early_val,
                            output int err_cnt, output int err_at);
    int  sent;
    int  cyc;
    logic v;
    sent = 0; cyc = 0; ok = 1'b1; early_val = 0; err_cnt = 0; err_at = -1;
    while (sent < nbeats) begin
      if (o_val) early_val++;
      if (o_err) begin
        if (err_cnt == 0) err_at = sent;
        err_cnt++;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_axis_tvalid = v;
      s_axis_tdata  = (sent < NUM_WORDS) ? fb[sent*AXI_LEN +: AXI_LEN] : AXI_LEN'($urandom);
      s_axis_tkeep  = 4'($urandom);
      s_axis_tlast  = (sent == tlast_at);
      ap_start      = (sent == 10);
      if (v && s_axis_tready) sent++;
      step();
      cyc++;
      if (cyc > 2000) begin
        ok = 1'b0;
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    ap_start      = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    logic [BUF_W-1:0] fb;
    bit ok;
    int ev, ec, ea, bad;
    fb = build_frame(v);
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    send_beats(fb, NUM_WORDS, v.tlast_at, v.mode, ok, ev, ec, ea);
    chk($sformatf("v%0d_recv_done", idx), ok, 1);
    chk($sformatf("v%0d_no_early_val", idx), ev, 0);
    chk($sformatf("v%0d_no_err", idx), ec + int'(o_err), 0);
    chk($sformatf("v%0d_val_latency", idx), o_val, 1);
    chk($sformatf("v%0d_hold_ready", idx), s_axis_tready, 0);
    chk($sformatf("v%0d_start_cnt", idx), o_start_cnt, v.start_cnt);
    chk($sformatf("v%0d_end_cnt", idx), o_end_cnt, v.end_cnt);
    chk($sformatf("v%0d_value", idx), o_value, v.value);
    bad = 0;
    for (int c = 0; c < v.rdy_delay; c++) begin
      ap_start      = (c == v.rdy_delay / 2);
      s_axis_tvalid = 1'($urandom_range(0, 1));
      s_axis_tdata  = $urandom;
      step();
      if (!o_val || s_axis_tready || o_start_cnt !== v.start_cnt || o_end_cnt !== v.end_cnt ||
          o_value !== v.value) bad++;
    end
    ap_start      = 1'b0;
    s_axis_tvalid = 1'b0;
    chk($sformatf("v%0d_hold_stable", idx), bad, 0);
    i_rdy = 1'b1;
    step();
    i_rdy = 1'b0;
    chk($sformatf("v%0d_val_drop", idx), o_val, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = $urandom;
    step();
    step();
    s_axis_tvalid = 1'b0;
    chk($sformatf("v%0d_idle_ready", idx), s_axis_tready, 0);
    chk($sformatf("v%0d_idle_keep", idx), o_value, v.value);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DAT_BITS-1:0] mont_two;
    logic [BUF_W-1:0]    fb;
    vec_t rv;
    bit   ok;
    int   ev, ec, ea, bad;

    // Stand-in for to_mont(2); the deserializer is agnostic to the value's meaning.
    mont_two = {32{32'hA5C3_0F96}};
    vecs[0] = '{64'd0, 64'd100000, mont_two, 0, NUM_WORDS - 1, 0};
    vecs[1] = '{64'd0, 64'd100000, mont_two, 1, NUM_WORDS - 1, 50};
    vecs[2] = '{{$urandom, $urandom}, {$urandom, $urandom}, rand_value(), 2, NUM_WORDS - 1,
                int'($urandom_range(1, 20))};
    vecs[3] = '{'1, '1, '1, 0, NUM_WORDS - 1, 3};
    vecs[4] = '{'0, '0, '0, 2, NUM_WORDS - 1, 5};
    vecs[5] = '{{$urandom, $urandom}, {$urandom, $urandom}, rand_value(), 1, ODD_TLAST, 2};
    vecs[6] = '{{$urandom, $urandom}, {$urandom, $urandom}, rand_value(), 2, NUM_WORDS - 1,
                int'($urandom_range(0, 30))};

    #2 reset = 1'b1;
    #1;
    chk("reset_ready", s_axis_tready, 0);
    chk("reset_val", o_val, 0);
    chk("reset_err", o_err, 0);
    chk("reset_start", o_start_cnt, 0);
    chk("reset_end", o_end_cnt, 0);
    chk("reset_value", o_value, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // Beats before ap_start must be refused.
    bad = 0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      s_axis_tdata = $urandom;
      step();
      if (s_axis_tready || o_val) bad++;
    end
    s_axis_tvalid = 1'b0;
    chk("pre_start_refused", bad, 0);
    chk("pre_start_value", o_value, 0);

    for (int i = 0; i < NVEC; i++) run_frame(vecs[i], i);

    // Reset after beat 10 drops the partial frame; no beats until a fresh ap_start.
    rv = '{64'd5, {$urandom, $urandom}, rand_value(), 0, NUM_WORDS - 1, 4};
    fb = build_frame('{{$urandom, $urandom}, {$urandom, $urandom}, rand_value(), 0, -1, 0});
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    send_beats(fb, 11, -1, 0, ok, ev, ec, ea);
    chk("midrst_recv_done", ok, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", s_axis_tready, 0);
    chk("midrst_start", o_start_cnt, 0);
    chk("midrst_value", o_value, 0);
    step();
    reset = 1'b0;
    bad = 0;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      s_axis_tdata = $urandom;
      step();
      if (s_axis_tready || o_val) bad++;
    end
    s_axis_tvalid = 1'b0;
    chk("midrst_no_accept", bad, 0);
    run_frame(rv, 100);

`ifdef MSU_DESER_LEN_CHECK_EN
    // Short frame: tlast on beat 20.
    fb = build_frame(vecs[2]);
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    send_beats(fb, 21, 20, 0, ok, ev, ec, ea);
    chk("short_recv_done", ok, 1);
    chk("short_err_pulse", o_err, 1);
    chk("short_no_val", o_val, 0);
    chk("short_idle_ready", s_axis_tready, 0);
    step();
    chk("short_err_single", o_err, 0);
    chk("short_still_no_val", o_val, 0);

    // Long frame: 40 beats, tlast on beat 39.
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    send_beats(fb, 40, 39, 0, ok, ev, ec, ea);
    chk("long_recv_done", ok, 1);
    chk("long_err_count", ec + int'(o_err), 1);
    chk("long_err_at", ea, NUM_WORDS);
    chk("long_no_val_during", ev, 0);
    chk("long_no_val", o_val, 0);
    chk("long_idle_ready", s_axis_tready, 0);
    step();
    chk("long_still_no_val", o_val, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
